// File: rtl/ariane_pkg.sv
// Shared scoreboard types and sizing constants.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned NR_WB_PORTS   = 3;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  // Functional unit an instruction is dispatched to; NONE means it writes no register.
  typedef enum logic [2:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/sb_rd_lookup.sv
// Youngest-match operand lookup for one source register.
// Walks the in-flight entries oldest to youngest so the last hit is the youngest writer.
module sb_rd_lookup
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES    = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  scoreboard_entry [NR_ENTRIES-1:0] entries_i,
  input  logic [NR_ENTRIES-1:0]            allocated_i,
  input  logic [TRANS_ID_BITS-1:0]         head_i,
  input  logic [4:0]                       rs_i,
  output logic [63:0]                      data_o,
  output logic                             valid_o
);

  logic [TRANS_ID_BITS-1:0] idx;
  logic [63:0]              hit_data;
  logic                     hit_valid;

  // Age-ordered scan; a younger pending writer overrides an older completed one.
  always_comb begin
    idx       = '0;
    hit_data  = '0;
    hit_valid = 1'b0;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      idx = head_i + TRANS_ID_BITS'(k);
      if (allocated_i[idx] && entries_i[idx].rd == rs_i && entries_i[idx].fu != NONE) begin
        hit_valid = entries_i[idx].valid;
        hit_data  = entries_i[idx].result;
      end
    end
    valid_o = (rs_i != 5'd0) && hit_valid;
    data_o  = valid_o ? hit_data : 64'd0;
  end

endmodule

// File: rtl/scoreboard.sv
// In-order instruction scoreboard: circular buffer of in-flight entries with
// multi-port writeback, in-order commit and a pending-write (clobber) vector.
// Optional operand forwarding to issue is built when SB_FORWARD_EN is defined.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES    = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS   = ariane_pkg::NR_WB_PORTS,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  output logic                                      full_o,
  input  scoreboard_entry                           decoded_instr_i,
  input  logic                                      decoded_instr_valid_i,
  output logic                                      decoded_instr_ack_o,
  output logic [TRANS_ID_BITS-1:0]                  trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]              wb_data_i,
  input  exception [NR_WB_PORTS-1:0]                wb_ex_i,
  output scoreboard_entry                           commit_instr_o,
  output logic                                      commit_valid_o,
  input  logic                                      commit_ack_i,
  output logic [31:0]                               rd_clobber_o,
  input  logic [4:0]                                rs1_i,
  input  logic [4:0]                                rs2_i,
  output logic [63:0]                               rs1_o,
  output logic [63:0]                               rs2_o,
  output logic                                      rs1_valid_o,
  output logic                                      rs2_valid_o
);

  scoreboard_entry          mem_reg  [NR_ENTRIES];
  scoreboard_entry          mem_next [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]    allocated_reg, allocated_next;
  logic [TRANS_ID_BITS-1:0] head_reg, head_next;
  logic [TRANS_ID_BITS-1:0] tail_reg, tail_next;
  logic [TRANS_ID_BITS:0]   count_reg, count_next;
  logic                     alloc, pop;

  logic                     wb_hit     [NR_ENTRIES];
  logic [63:0]              wb_data_sel[NR_ENTRIES];
  exception                 wb_ex_sel  [NR_ENTRIES];

  assign full_o              = (count_reg == (TRANS_ID_BITS+1)'(NR_ENTRIES));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign alloc               = decoded_instr_ack_o;
  assign trans_id_o          = tail_reg;
  assign commit_instr_o      = mem_reg[head_reg];
  assign commit_valid_o      = allocated_reg[head_reg] & mem_reg[head_reg].valid;
  assign pop                 = commit_ack_i & commit_valid_o;

  // Per-entry writeback select; scanning high to low lets the lowest port win.
  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_wb_sel
    always_comb begin
      wb_hit[gi]      = 1'b0;
      wb_data_sel[gi] = '0;
      wb_ex_sel[gi]   = '0;
      for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && wb_trans_id_i[p] == TRANS_ID_BITS'(gi)) begin
          wb_hit[gi]      = 1'b1;
          wb_data_sel[gi] = wb_data_i[p];
          wb_ex_sel[gi]   = wb_ex_i[p];
        end
      end
    end
  end

  // Next-state: flush overrides everything, otherwise writeback, pop and allocate.
  always_comb begin
    mem_next       = mem_reg;
    allocated_next = allocated_reg;
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_next[i].valid = 1'b0;
      allocated_next = '0;
      head_next      = '0;
      tail_next      = '0;
      count_next     = '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (allocated_reg[i] && wb_hit[i]) begin
          mem_next[i].result = wb_data_sel[i];
          mem_next[i].valid  = 1'b1;
          if (wb_ex_sel[i].valid) mem_next[i].ex = wb_ex_sel[i];
        end
      end
      if (pop) begin
        allocated_next[head_reg] = 1'b0;
        head_next                = head_reg + TRANS_ID_BITS'(1);
      end
      // The tail slot is never allocated when alloc fires, so no writeback can collide.
      if (alloc) begin
        mem_next[tail_reg]          = decoded_instr_i;
        mem_next[tail_reg].trans_id = tail_reg;
        mem_next[tail_reg].valid    = 1'b0;
        allocated_next[tail_reg]    = 1'b1;
        tail_next                   = tail_reg + TRANS_ID_BITS'(1);
      end
      if (alloc && !pop)      count_next = count_reg + (TRANS_ID_BITS+1)'(1);
      else if (!alloc && pop) count_next = count_reg - (TRANS_ID_BITS+1)'(1);
    end
  end

  // State register; reset also clears the entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_reg[i] <= '0;
      allocated_reg <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_reg[i] <= mem_next[i];
      allocated_reg <= allocated_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
    end
  end

  // Pending-write vector; x0 is never reported as clobbered.
  always_comb begin
    rd_clobber_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (allocated_reg[i] && mem_reg[i].fu != NONE) rd_clobber_o[mem_reg[i].rd] = 1'b1;
    end
    rd_clobber_o[0] = 1'b0;
  end

`ifdef SB_FORWARD_EN
  scoreboard_entry [NR_ENTRIES-1:0] entries_flat;

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_flat
    assign entries_flat[gi] = mem_reg[gi];
  end

  sb_rd_lookup #(
    .NR_ENTRIES   (NR_ENTRIES),
    .TRANS_ID_BITS(TRANS_ID_BITS)
  ) i_rs1_lookup (
    .entries_i  (entries_flat),
    .allocated_i(allocated_reg),
    .head_i     (head_reg),
    .rs_i       (rs1_i),
    .data_o     (rs1_o),
    .valid_o    (rs1_valid_o)
  );

  sb_rd_lookup #(
    .NR_ENTRIES   (NR_ENTRIES),
    .TRANS_ID_BITS(TRANS_ID_BITS)
  ) i_rs2_lookup (
    .entries_i  (entries_flat),
    .allocated_i(allocated_reg),
    .head_i     (head_reg),
    .rs_i       (rs2_i),
    .data_o     (rs2_o),
    .valid_o    (rs2_valid_o)
  );
`else
  logic unused_rs;
  assign unused_rs   = ^{rs1_i, rs2_i};
  assign rs1_o       = '0;
  assign rs2_o       = '0;
  assign rs1_valid_o = 1'b0;
  assign rs2_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios plus a randomized run
// against a queue-based model of the in-flight instruction window.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N  = NR_SB_ENTRIES;
  localparam int P  = NR_WB_PORTS;
  localparam int TB = TRANS_ID_BITS;

  logic                      clk, rst, flush;
  logic                      full;
  scoreboard_entry           din;
  logic                      dvalid, dack;
  logic [TB-1:0]             trans_id;
  logic [P-1:0]              wb_valid;
  logic [P-1:0][TB-1:0]      wb_trans_id;
  logic [P-1:0][63:0]        wb_data;
  exception [P-1:0]          wb_ex;
  scoreboard_entry           commit_instr;
  logic                      commit_valid, commit_ack;
  logic [31:0]               clobber;
  logic [4:0]                rs1, rs2;
  logic [63:0]               rs1_d, rs2_d;
  logic                      rs1_v, rs2_v;

  int checks = 0;
  int errors = 0;

  // Model: program-ordered queue of in-flight entries and the next ID to hand out.
  scoreboard_entry q[$];
  int              m_tail = 0;

  scoreboard dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
    .decoded_instr_i(din), .decoded_instr_valid_i(dvalid), .decoded_instr_ack_o(dack),
    .trans_id_o(trans_id), .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id),
    .wb_data_i(wb_data), .wb_ex_i(wb_ex), .commit_instr_o(commit_instr),
    .commit_valid_o(commit_valid), .commit_ack_i(commit_ack), .rd_clobber_o(clobber),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_o(rs1_d), .rs2_o(rs2_d),
    .rs1_valid_o(rs1_v), .rs2_valid_o(rs2_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic scoreboard_entry rand_instr(input logic [4:0] rd, input fu_t fu);
    scoreboard_entry e;
    e          = '0;
    e.pc       = {$urandom, $urandom};
    e.trans_id = TB'($urandom_range(0, N - 1));
    e.fu       = fu;
    e.rs1      = 5'($urandom_range(0, 31));
    e.rs2      = 5'($urandom_range(0, 31));
    e.rd       = rd;
    e.result   = {$urandom, $urandom};
    e.valid    = 1'($urandom_range(0, 1));
    e.ex       = {$urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1))};
    return e;
  endfunction

  function automatic logic [31:0] exp_clobber();
    logic [31:0] c;
    c = '0;
    foreach (q[j]) if (q[j].fu != NONE) c[q[j].rd] = 1'b1;
    c[0] = 1'b0;
    return c;
  endfunction

  // Youngest in-flight writer of rs decides the forwarded value.
  function automatic void exp_fwd(input logic [4:0] rs, output logic [63:0] d, output logic v);
    d = '0;
    v = 1'b0;
    if (rs != 5'd0) begin
`ifdef SB_FORWARD_EN
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].rd == rs && q[j].fu != NONE) begin
          if (q[j].valid) begin
            d = q[j].result;
            v = 1'b1;
          end
          break;
        end
      end
`endif
    end
  endfunction

  // Model update for one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit              do_pop, acc;
    bit              taken[N];
    scoreboard_entry t;
    if (flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    do_pop = commit_ack && q.size() > 0 && q[0].valid;
    acc    = dvalid && q.size() < N;
    foreach (taken[j]) taken[j] = 1'b0;
    for (int p = 0; p < P; p++) begin
      if (wb_valid[p] && !taken[int'(wb_trans_id[p])]) begin
        taken[int'(wb_trans_id[p])] = 1'b1;
        foreach (q[j]) begin
          if (q[j].trans_id == wb_trans_id[p]) begin
            t        = q[j];
            t.result = wb_data[p];
            t.valid  = 1'b1;
            if (wb_ex[p].valid) t.ex = wb_ex[p];
            q[j]     = t;
          end
        end
      end
    end
    if (do_pop) begin
      $display("[%0t] commit id=%0d rd=%0d result=%h", $time, q[0].trans_id, q[0].rd, q[0].result);
      void'(q.pop_front());
    end
    if (acc) begin
      t          = din;
      t.trans_id = TB'(m_tail);
      t.valid    = 1'b0;
      q.push_back(t);
      $display("[%0t] alloc  id=%0d rd=%0d fu=%0d", $time, m_tail, t.rd, t.fu);
      m_tail = (m_tail + 1) % N;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    flush = 0; dvalid = 0; din = '0; wb_valid = '0; wb_trans_id = '0;
    wb_data = '0; wb_ex = '0; commit_ack = 0; rs1 = '0; rs2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (dack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", dack); end
    checks++; if (trans_id !== '0) begin errors++; $display("FAIL reset_trans_id: got %0d expected 0", trans_id); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
    checks++; if (commit_instr !== '0) begin errors++; $display("FAIL reset_commit_instr: got %h expected 0", commit_instr); end
    checks++; if (clobber !== '0) begin errors++; $display("FAIL reset_clobber: got %h expected 0", clobber); end
    checks++; if ({rs1_v, rs2_v, rs1_d, rs2_d} !== '0) begin errors++; $display("FAIL reset_fwd: got %b/%b %h/%h expected all 0", rs1_v, rs2_v, rs1_d, rs2_d); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_tail = 0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      dvalid = 1; din = rand_instr(5'(i + 1), ALU);
      #1;
      checks++; if (dack !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d]: got %b expected 1", i, dack); end
      checks++; if (trans_id !== TB'(i)) begin errors++; $display("FAIL fill_id[%0d]: got %0d expected %0d", i, trans_id, i); end
      step();
    end
    din = rand_instr(5'd9, ALU);
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    checks++; if (dack !== 1'b0) begin errors++; $display("FAIL fill_fifth_ack: got %b expected 0", dack); end
    step();
    dvalid = 0;
    for (int k = 3; k >= 0; k--) begin
      wb_valid = 3'b001; wb_trans_id[0] = TB'(k); wb_data[0] = 64'h100 + 64'(k);
      #1;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL drain_early_valid[%0d]: got %b expected 0", k, commit_valid); end
      step();
    end
    wb_valid = '0;
    for (int k = 0; k < 4; k++) begin
      commit_ack = 1;
      #1;
      checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", k, commit_valid); end
      checks++; if (commit_instr.trans_id !== TB'(k) || commit_instr.result !== 64'h100 + 64'(k)) begin
        errors++; $display("FAIL drain_order[%0d]: got id %0d result %h expected id %0d result %h",
                           k, commit_instr.trans_id, commit_instr.result, k, 64'h100 + 64'(k));
      end
      step();
    end
    commit_ack = 0;
    #1;
    checks++; if (commit_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid %b full %b expected 0 0", commit_valid, full); end
  endtask

  task automatic test_collision();
    dvalid = 1; din = rand_instr(5'd3, ALU); step();
    din = rand_instr(5'd4, ALU); step();
    dvalid = 0;
    wb_valid = 3'b111;
    wb_trans_id[0] = TB'(1); wb_data[0] = 64'hAA;
    wb_trans_id[1] = TB'(0); wb_data[1] = 64'hCC;
    wb_trans_id[2] = TB'(1); wb_data[2] = 64'hBB;
    step();
    wb_valid = '0; commit_ack = 1;
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'hCC) begin errors++; $display("FAIL coll_head0: got valid %b result %h expected 1 cc", commit_valid, commit_instr.result); end
    step();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'hAA) begin errors++; $display("FAIL coll_lowest_port: got valid %b result %h expected 1 aa", commit_valid, commit_instr.result); end
    step();
    commit_ack = 0;
  endtask

  task automatic test_wrap();
    flush = 1; step(); flush = 0;
    for (int k = 0; k < 12; k++) begin
      dvalid = (k < 10); din = rand_instr(5'd6, ALU);
      wb_valid = (k >= 1 && k <= 10) ? 3'b001 : 3'b000;
      wb_trans_id[0] = TB'((k + 3) % 4); wb_data[0] = 64'(k) + 64'h500;
      commit_ack = (k >= 2);
      #1;
      if (k < 10) begin
        checks++; if (dack !== 1'b1 || trans_id !== TB'(k % 4)) begin errors++; $display("FAIL wrap_id[%0d]: got ack %b id %0d expected 1 %0d", k, dack, trans_id, k % 4); end
      end
      if (k >= 2) begin
        checks++; if (commit_valid !== 1'b1 || commit_instr.trans_id !== TB'((k + 2) % 4)) begin
          errors++; $display("FAIL wrap_commit[%0d]: got valid %b id %0d expected 1 %0d", k, commit_valid, commit_instr.trans_id, (k + 2) % 4);
        end
      end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d]: got %b expected 0", k, full); end
      step();
    end
    idle();
  endtask

  task automatic test_clobber();
    dvalid = 1; din = rand_instr(5'd5, ALU); step();
    din = rand_instr(5'd0, ALU); step();
    dvalid = 0;
    #1;
    checks++; if (clobber !== 32'h20) begin errors++; $display("FAIL clobber_set: got %h expected 00000020", clobber); end
    wb_valid = 3'b011;
    wb_trans_id[0] = q[0].trans_id; wb_trans_id[1] = q[1].trans_id;
    step();
    wb_valid = '0; commit_ack = 1; step(); commit_ack = 0;
    #1;
    checks++; if (clobber !== 32'h0) begin errors++; $display("FAIL clobber_clear: got %h expected 00000000", clobber); end
    commit_ack = 1; step(); commit_ack = 0;
  endtask

  task automatic test_flush();
    dvalid = 1;
    for (int i = 0; i < 3; i++) begin din = rand_instr(5'(10 + i), LOAD); step(); end
    flush = 1; din = rand_instr(5'd20, ALU);
    wb_valid = 3'b001; wb_trans_id[0] = q[0].trans_id; wb_data[0] = 64'h77;
    #1;
    checks++; if (dack !== 1'b0) begin errors++; $display("FAIL flush_ack: got %b expected 0", dack); end
    step();
    idle();
    #1;
    checks++; if (commit_valid !== 1'b0 || clobber !== '0 || full !== 1'b0 || trans_id !== '0) begin
      errors++; $display("FAIL flush_state: got valid %b clobber %h full %b id %0d expected 0 0 0 0", commit_valid, clobber, full, trans_id);
    end
    dvalid = 1; din = rand_instr(5'd11, ALU); step();
    din = rand_instr(5'd12, ALU); step();
    dvalid = 0; wb_valid = 3'b001; wb_trans_id[0] = TB'(0); wb_data[0] = 64'h99; step();
    wb_valid = '0;
    #1;
    checks++; if (commit_valid !== 1'b1 || clobber !== 32'h1800) begin errors++; $display("FAIL prereset_state: got valid %b clobber %h expected 1 00001800", commit_valid, clobber); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (commit_valid !== 1'b0 || commit_instr !== '0 || clobber !== '0 || trans_id !== '0 || full !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid %b instr %h clobber %h id %0d full %b expected all 0", commit_valid, commit_instr, clobber, trans_id, full);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_tail = 0;
  endtask

  task automatic test_forward();
    logic [63:0] exp_d;
    logic        exp_v;
    dvalid = 1; din = rand_instr(5'd7, ALU); step();
    din = rand_instr(5'd7, MULT); step();
    dvalid = 0; wb_valid = 3'b001; wb_trans_id[0] = TB'(0); wb_data[0] = 64'h11; step();
    wb_valid = '0; rs1 = 5'd7; rs2 = 5'd0;
    #1;
    checks++; if (rs1_v !== 1'b0 || rs1_d !== '0) begin errors++; $display("FAIL fwd_young_pending: got %b %h expected 0 0", rs1_v, rs1_d); end
    wb_valid = 3'b100; wb_trans_id[2] = TB'(1); wb_data[2] = 64'h22;
    #1;
    checks++; if (rs1_v !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle_wb: got %b expected 0", rs1_v); end
    step();
    wb_valid = '0;
`ifdef SB_FORWARD_EN
    exp_d = 64'h22; exp_v = 1'b1;
`else
    exp_d = 64'h0;  exp_v = 1'b0;
`endif
    #1;
    checks++; if (rs1_v !== exp_v || rs1_d !== exp_d) begin errors++; $display("FAIL fwd_young_done: got %b %h expected %b %h", rs1_v, rs1_d, exp_v, exp_d); end
    checks++; if (rs2_v !== 1'b0 || rs2_d !== '0) begin errors++; $display("FAIL fwd_x0: got %b %h expected 0 0", rs2_v, rs2_d); end
    rs2 = 5'd7;
    #1;
    checks++; if (rs2_v !== exp_v || rs2_d !== exp_d) begin errors++; $display("FAIL fwd_rs2: got %b %h expected %b %h", rs2_v, rs2_d, exp_v, exp_d); end
    flush = 1; step(); idle();
  endtask

  task automatic test_random();
    logic [63:0] e1d, e2d;
    logic        e1v, e2v;
    for (int c = 0; c < 400; c++) begin
      flush      = ($urandom_range(0, 39) == 0);
      dvalid     = 1'($urandom_range(0, 1));
      din        = rand_instr(5'($urandom_range(0, 7)), fu_t'(3'($urandom_range(0, 6))));
      wb_valid   = P'($urandom);
      for (int p = 0; p < P; p++) begin
        wb_trans_id[p] = TB'($urandom_range(0, N - 1));
        wb_data[p]     = {$urandom, $urandom};
        wb_ex[p]       = {$urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) == 0)};
      end
      commit_ack = 1'($urandom_range(0, 1));
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      #1;
      exp_fwd(rs1, e1d, e1v);
      exp_fwd(rs2, e2d, e2v);
      checks++; if (dack !== (dvalid && !flush && q.size() < N)) begin errors++; $display("FAIL rnd_ack[%0d]: got %b expected %b", c, dack, dvalid && !flush && q.size() < N); end
      checks++; if (full !== (q.size() == N)) begin errors++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, full, q.size() == N); end
      checks++; if (trans_id !== TB'(m_tail)) begin errors++; $display("FAIL rnd_id[%0d]: got %0d expected %0d", c, trans_id, m_tail); end
      checks++; if (commit_valid !== (q.size() > 0 && q[0].valid)) begin errors++; $display("FAIL rnd_commit_valid[%0d]: got %b expected %b", c, commit_valid, q.size() > 0 && q[0].valid); end
      if (q.size() > 0) begin
        checks++; if (commit_instr !== q[0]) begin errors++; $display("FAIL rnd_commit_instr[%0d]: got %h expected %h", c, commit_instr, q[0]); end
      end
      checks++; if (clobber !== exp_clobber()) begin errors++; $display("FAIL rnd_clobber[%0d]: got %h expected %h", c, clobber, exp_clobber()); end
      checks++; if (rs1_v !== e1v || rs1_d !== e1d) begin errors++; $display("FAIL rnd_rs1[%0d]: got %b %h expected %b %h", c, rs1_v, rs1_d, e1v, e1d); end
      checks++; if (rs2_v !== e2v || rs2_d !== e2d) begin errors++; $display("FAIL rnd_rs2[%0d]: got %b %h expected %b %h", c, rs2_v, rs2_d, e2v, e2d); end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_collision();
    test_wrap();
    test_clobber();
    test_flush();
    test_forward();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
